// File: rtl/seg_mux_scheduler.sv
// seg_mux_scheduler: time-multiplexes one hex-to-7-segment decoder across two
// common-anode digits, with a blanking gap before each digit to stop ghosting.
// Optional feature macro: SEG_MUX_LEADING_ZERO_BLANK_EN (blank a leading zero
// on the left digit).
`timescale 1ns/1ps

module seg_mux_scheduler #(
    parameter int unsigned SHOW_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [3:0] s_sel,
    output logic [1:0] anode_n,
    output logic       slot,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [3:0]       s_sel_d;
    logic [1:0]       anode_d;
    logic             slot_d;
    logic             tick_d;
    logic             dwell_done;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
    logic             sup_q, sup_d;
`endif

    // State, dwell counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BLANK0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            s_sel      <= 4'h0;
            anode_n    <= 2'b11;
            slot       <= 1'b0;
            frame_tick <= 1'b0;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
            sup_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            s_sel      <= s_sel_d;
            anode_n    <= anode_d;
            slot       <= slot_d;
            frame_tick <= tick_d;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
            sup_q      <= sup_d;
`endif
        end
    end

    // Next state and next output values; outputs only change on state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        s_sel_d = s_sel;
        anode_d = anode_n;
        slot_d  = slot;
        tick_d  = 1'b0;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        sup_d   = sup_q;
`endif
        dwell_done = ((state_q == BLANK0) || (state_q == BLANK1)) ?
                     (cnt_q == BLANK_LAST) : (cnt_q == SHOW_LAST);

        if (!enable) begin
            // Scan off: park in BLANK0; run_q low so the next enabled edge
            // restarts a full blank interval.
            state_d = BLANK0;
            cnt_d   = '0;
            run_d   = 1'b0;
            s_sel_d = digit0;
            anode_d = 2'b11;
            slot_d  = 1'b0;
        end else if (!run_q) begin
            // First enabled edge after reset or a disable: fresh BLANK0 entry
            state_d = BLANK0;
            cnt_d   = '0;
            run_d   = 1'b1;
            s_sel_d = digit0;
            anode_d = 2'b11;
            slot_d  = 1'b0;
        end else if (!dwell_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            case (state_q)
                BLANK0: begin
                    state_d = SHOW0;
                    anode_d = 2'b10;
                end
                SHOW0: begin
                    state_d = BLANK1;
                    anode_d = 2'b11;
                    s_sel_d = digit1;
                    slot_d  = 1'b1;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
                    sup_d   = (digit1 == 4'h0);
`endif
                end
                BLANK1: begin
                    state_d = SHOW1;
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
                    anode_d = sup_q ? 2'b11 : 2'b01;
`else
                    anode_d = 2'b01;
`endif
                end
                SHOW1: begin
                    state_d = BLANK0;
                    anode_d = 2'b11;
                    s_sel_d = digit0;
                    slot_d  = 1'b0;
                    tick_d  = 1'b1;
                end
                default: begin
                    state_d = BLANK0;
                    anode_d = 2'b11;
                    s_sel_d = digit0;
                    slot_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Self-checking bench for seg_mux_scheduler with SHOW_CYCLES=4, BLANK_CYCLES=2.
`timescale 1ns/1ps

module tb_seg_mux_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] s_sel;
    logic [1:0] anode_n;
    logic       slot;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    seg_mux_scheduler #(
        .SHOW_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .digit0    (digit0),
        .digit1    (digit1),
        .s_sel     (s_sel),
        .anode_n   (anode_n),
        .slot      (slot),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] an;
        logic [3:0] ss;
        logic       sl;
        logic       tk;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic en, input logic [3:0] d0, input logic [3:0] d1,
                                input logic [1:0] an, input logic [3:0] ss,
                                input logic sl, input logic tk);
        vec_t v;
        v.en = en; v.d0 = d0; v.d1 = d1; v.an = an; v.ss = ss; v.sl = sl; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_anode(input string nm, input logic [1:0] tgt);
        int n = 0;
        while (anode_n !== tgt && n < 40) begin
            step();
            n++;
        end
        chk(nm, 8'(anode_n), 8'(tgt));
    endtask

    task automatic wait_tick(input string nm);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(nm, 8'(frame_tick), 8'd1);
    endtask

    initial begin
        logic [1:0] exp_lz;
        logic [1:0] prev_an;
        logic [3:0] prev_ss;

        // One frame: BLANK0 2, SHOW0 4, BLANK1 2, SHOW1 4; digit0 -> 7 mid-SHOW0
        tbl[0]  = mk(1, 4'h3, 4'hA, 2'b11, 4'h3, 0, 0);
        tbl[1]  = mk(1, 4'h3, 4'hA, 2'b11, 4'h3, 0, 0);
        tbl[2]  = mk(1, 4'h3, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[3]  = mk(1, 4'h3, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[4]  = mk(1, 4'h3, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[5]  = mk(1, 4'h3, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[6]  = mk(1, 4'h3, 4'hA, 2'b11, 4'hA, 1, 0);
        tbl[7]  = mk(1, 4'h3, 4'hA, 2'b11, 4'hA, 1, 0);
        tbl[8]  = mk(1, 4'h3, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[9]  = mk(1, 4'h3, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[10] = mk(1, 4'h3, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[11] = mk(1, 4'h3, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[12] = mk(1, 4'h3, 4'hA, 2'b11, 4'h3, 0, 1);
        tbl[13] = mk(1, 4'h3, 4'hA, 2'b11, 4'h3, 0, 0);
        tbl[14] = mk(1, 4'h3, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[15] = mk(1, 4'h7, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[16] = mk(1, 4'h7, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[17] = mk(1, 4'h7, 4'hA, 2'b10, 4'h3, 0, 0);
        tbl[18] = mk(1, 4'h7, 4'hA, 2'b11, 4'hA, 1, 0);
        tbl[19] = mk(1, 4'h7, 4'hA, 2'b11, 4'hA, 1, 0);
        tbl[20] = mk(1, 4'h7, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[21] = mk(1, 4'h7, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[22] = mk(1, 4'h7, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[23] = mk(1, 4'h7, 4'hA, 2'b01, 4'hA, 1, 0);
        tbl[24] = mk(1, 4'h7, 4'hA, 2'b11, 4'h7, 0, 1);
        tbl[25] = mk(1, 4'h7, 4'hA, 2'b11, 4'h7, 0, 0);
        tbl[26] = mk(1, 4'h7, 4'hA, 2'b10, 4'h7, 0, 0);

        reset_n = 1'b0;
        enable  = 1'b1;
        digit0  = 4'h3;
        digit1  = 4'hA;
        repeat (2) @(negedge clk);
        chk("rst_anode", 8'(anode_n), 8'h3);
        chk("rst_ssel", 8'(s_sel), 8'h0);
        chk("rst_slot", 8'(slot), 8'h0);
        chk("rst_tick", 8'(frame_tick), 8'h0);
        reset_n = 1'b1;

        // First two frames from the vector table
        for (int i = 0; i < 27; i++) begin
            enable = tbl[i].en;
            digit0 = tbl[i].d0;
            digit1 = tbl[i].d1;
            step();
            chk($sformatf("tbl%0d_anode", i), 8'(anode_n), 8'(tbl[i].an));
            chk($sformatf("tbl%0d_ssel", i), 8'(s_sel), 8'(tbl[i].ss));
            chk($sformatf("tbl%0d_slot", i), 8'(slot), 8'(tbl[i].sl));
            chk($sformatf("tbl%0d_tick", i), 8'(frame_tick), 8'(tbl[i].tk));
        end

        // Enable drop at the start of SHOW1 for 5 cycles
        wait_anode("reach_show1", 2'b01);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b0;
            step();
            chk("dis_anode", 8'(anode_n), 8'h3);
            chk("dis_slot", 8'(slot), 8'h0);
            chk("dis_ssel", 8'(s_sel), 8'h7);
            chk("dis_tick", 8'(frame_tick), 8'h0);
        end
        enable = 1'b1;
        step();
        chk("reen_blank_a", 8'(anode_n), 8'h3);
        step();
        chk("reen_blank_b", 8'(anode_n), 8'h3);
        step();
        chk("reen_show0", 8'(anode_n), 8'h2);

        // Async reset pulse between clock edges in SHOW0
        step();
        chk("pre_rst_show0", 8'(anode_n), 8'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_anode", 8'(anode_n), 8'h3);
        chk("arst_ssel", 8'(s_sel), 8'h0);
        chk("arst_slot", 8'(slot), 8'h0);
        chk("arst_tick", 8'(frame_tick), 8'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_blank_a", 8'(anode_n), 8'h3);
        chk("post_rst_ssel", 8'(s_sel), 8'h7);
        step();
        chk("post_rst_blank_b", 8'(anode_n), 8'h3);
        step();
        chk("post_rst_show0", 8'(anode_n), 8'h2);

        // Leading zero on the left digit
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        exp_lz = 2'b11;
`else
        exp_lz = 2'b01;
`endif
        wait_tick("lz_sync");
        digit1 = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i >= 8 && i <= 11) begin
                chk("lz0_anode", 8'(anode_n), 8'(exp_lz));
                chk("lz0_ssel", 8'(s_sel), 8'h0);
                chk("lz0_slot", 8'(slot), 8'h1);
            end
            if (i == 12) chk("lz0_period", 8'(frame_tick), 8'h1);
        end
        digit1 = 4'h5;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i >= 8 && i <= 11) begin
                chk("lz5_anode", 8'(anode_n), 8'h1);
                chk("lz5_ssel", 8'(s_sel), 8'h5);
            end
            if (i == 12) chk("lz5_period", 8'(frame_tick), 8'h1);
        end

        // 1000 frames of random digits: no overlap, s_sel stable while lit
        prev_an = anode_n;
        prev_ss = s_sel;
        for (int i = 0; i < 12000; i++) begin
            digit0 = 4'($urandom_range(0, 15));
            digit1 = 4'($urandom_range(0, 15));
            step();
            chk("no_overlap", 8'(anode_n == 2'b00), 8'h0);
            if (anode_n != 2'b11 && prev_an != 2'b11)
                chk("ssel_stable", 8'(s_sel), 8'(prev_ss));
            prev_an = anode_n;
            prev_ss = s_sel;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_mux_scheduler.md
# seg_mux_scheduler

Time-multiplexing scheduler that shares the single hex-to-seven-segment decoder between the two digits of the dual common-anode display. Each cycle it selects which 4-bit digit value drives the decoder input and which digit's anode transistor is on. A blanking interval between digits suppresses ghosting. It sits between the digit-value sources (switch banks or sum logic) and the decoder/anode pins at the FPGA top level.

## Interface
- `SHOW_CYCLES`, default 100000: clock cycles each digit is lit per slot; legal range 1 to 2^24-1.
- `BLANK_CYCLES`, default 1000: clock cycles both anodes are off before each digit is lit; legal range 1 to 2^24-1.
- `clk`  in  1  system clock (48 MHz HSOSC domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low forces both anodes off.
- `digit0`  in  4  hex value for the right digit.
- `digit1`  in  4  hex value for the left digit.
- `s_sel`  out  4  value to the shared decoder's 4-bit input; registered.
- `anode_n`  out  2  anode drives, active-low; bit 0 is the right digit, bit 1 the left; registered.
- `slot`  out  1  currently scheduled digit, 0 or 1; registered.
- `frame_tick`  out  1  one-cycle pulse on exiting SHOW1; registered.

## Operation
- FSM states: BLANK0, SHOW0, BLANK1, SHOW1. Cyclic order: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
- A 24-bit dwell counter counts cycles within a state. It clears on every state change.
- In a BLANK state, leave after BLANK_CYCLES cycles. In a SHOW state, leave after SHOW_CYCLES cycles.
- Entering BLANKx sets `s_sel` to the current `digitx` and `slot` to x. `anode_n` is 2'b11 throughout BLANKx.
- `s_sel` holds for all of BLANKx and SHOWx. Input changes during a slot are not seen until the next BLANK entry, so the decoder output is stable while the digit is lit.
- In SHOWx, only anode bit x is low: SHOW0 gives `anode_n`=2'b10, SHOW1 gives 2'b01.
- The two anodes are never low in the same cycle.
- `frame_tick`=1 in exactly the first cycle of BLANK0 after SHOW1.
- `enable` low, sampled at a rising edge, causes the next state to be BLANK0 with counter=0, `anode_n`=2'b11, `slot`=0 and `s_sel` loaded with `digit0`.
  - This overrides any transition due in the same cycle.
  - `frame_tick` is 0 in this case.
- While `enable` stays low, hold in BLANK0 with the counter at 0.
- On `enable` rising, BLANK0 runs a full BLANK_CYCLES interval before SHOW0.

## Timing
- Reset (async assert, any time, including mid-slot) gives state BLANK0, counter 0, `s_sel`=4'h0, `anode_n`=2'b11, `slot`=0, `frame_tick`=0.
- After `reset_n` is released, the first edge with `enable`=1 starts counting BLANK0.
- Frame period is 2×(BLANK_CYCLES+SHOW_CYCLES) cycles.
- Each anode has a duty cycle of SHOW_CYCLES/period.
- A change on `digitx` reaches `s_sel` at the next BLANKx entry: at most one frame period plus one cycle later.
- Every output is a flop output. There is no combinational path from any input to any output.

## Configuration
- Macro: `SEG_MUX_LEADING_ZERO_BLANK_EN`.
- Defined: on entry to BLANK1, if `digit1`==4'h0, SHOW1 keeps `anode_n`=2'b11. This blanks the leading zero.
  - State sequencing, dwell times and `frame_tick` are unchanged.
  - `s_sel` and `slot` update as normal.
  - The suppress decision is latched at BLANK1 entry.
- Undefined: SHOW1 always drives `anode_n`=2'b01.

## Test plan
- Reset and first frame, with SHOW_CYCLES=4, BLANK_CYCLES=2, `enable`=1, `digit0`=4'h3, `digit1`=4'hA. Release `reset_n`, then check:
  - 2 cycles at `anode_n`=11 with `s_sel`=3;
  - then 4 cycles at 10;
  - then 2 cycles at 11 with `s_sel`=A;
  - then 4 cycles at 01;
  - `frame_tick` high for 1 cycle at the start of the next BLANK0;
  - period 12 cycles.
- Input change mid-slot: change `digit0` from 3 to 7 during SHOW0. `s_sel` stays 3 until the next BLANK0 entry, then becomes 7.
- Enable drop mid-SHOW1: deassert `enable` for 5 cycles. Next cycle `anode_n`=11, `slot`=0, `s_sel`=`digit0`, no `frame_tick`. On re-enable, expect 2 blank cycles before SHOW0.
- Async reset mid-SHOW0: pulse `reset_n` low between clock edges. Outputs go to reset values immediately, without waiting for a clock edge. Scanning restarts at BLANK0.
- Overlap check: run 1000 frames with random digits. Assert `anode_n`!=2'b00 every cycle. Assert `s_sel` is stable whenever any anode is low.
- With `SEG_MUX_LEADING_ZERO_BLANK_EN` and `digit1`=0: SHOW1 keeps `anode_n`=11 and the period is still 12 cycles. Set `digit1`=5 and SHOW1 drives 01 from the next frame.
